wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the MEM/WB pipeline writeback and a

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_arb_fifo.sv | 89 ++++++++
 rtl/wb_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and constants for the register-file write-port arbiter.
//   wb_src_e : identifies which source drove the current register-file write.
//   RF_ZERO  : architectural zero register; writes to it are discarded.
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LU   = 2'd2
    } wb_src_e;

    localparam logic [4:0] RF_ZERO = 5'd0;

endpackage : wb_arb_pkg

// File: rtl/wb_arb_fifo.sv
// -----------------------------------------------------------------------------
// wb_arb_fifo
//   Small in-order FIFO holding long-latency results ({rd, data}) until the
//   register-file write port is free.
//   Ports:
//     clk, reset_n      clock / asynchronous active-low reset
//     push, push_data   enqueue request (ignored while full)
//     pop               dequeue request (ignored while empty)
//     full, empty       occupancy flags, from the registered count
//     count             number of valid entries
//     head              oldest entry (valid when !empty)
//   DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module wb_arb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 37,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count is
    // enough to discard its contents, and leaving it unreset keeps it mappable
    // to plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : wb_arb_fifo

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the MEM/WB writeback
//   and a long-latency (mul/div) unit. Pipeline writes always win; long-latency
//   results queue in wb_arb_fifo and drain on cycles with no pipeline write.
//   Ports:
//     clk, reset_n                 clock / asynchronous active-low reset
//     wb_valid, wb_rd, wb_data     pipeline writeback request
//     lu_valid, lu_rd, lu_data     long-latency result, accepted when lu_ready
//     lu_ready                     FIFO not full (registered count only)
//     rf_we, rf_rd, rf_wdata       registered register-file write
//     rf_src                       wb_src_e of the current write
//     lu_pending                   FIFO non-empty, for the hazard unit
//     starve_stall                 bubble request when the head waits too long
//   Build option: WB_ARB_STARVE_EN enables the head-age counter and a
//   registered starve_stall; without it starve_stall is tied to 0.
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [1:0]        rf_src,
    output logic              lu_pending,
    output logic              starve_stall
);

    localparam int                ENTRY_W = REG_AW + XLEN;
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [REG_AW-1:0] ZERO_RD = REG_AW'(RF_ZERO);

    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [REG_AW-1:0]  head_rd;
    logic [XLEN-1:0]    head_data;

    logic pipe_win;
    logic lu_push;
    logic lu_pop;

    logic              rf_we_q,    rf_we_d;
    logic [REG_AW-1:0] rf_rd_q,    rf_rd_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    wb_src_e           rf_src_q,   rf_src_d;

    assign {head_rd, head_data} = fifo_head;

    // lu_ready depends only on the registered count, so a full FIFO never
    // accepts a push even in a cycle where it also pops.
    assign lu_ready   = !fifo_full;
    assign lu_pending = (fifo_count != '0);

    wb_arb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (lu_push),
        .push_data ({lu_rd, lu_data}),
        .pop       (lu_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        pipe_win = wb_valid && (wb_rd != ZERO_RD);
        // A result for x0 completes its handshake but is never stored.
        lu_push  = lu_valid && lu_ready && (lu_rd != ZERO_RD);
        lu_pop   = !pipe_win && !fifo_empty;

        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        rf_src_d   = SRC_NONE;
        if (pipe_win) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = wb_rd;
            rf_wdata_d = wb_data;
            rf_src_d   = SRC_PIPE;
        end else if (lu_pop) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = head_rd;
            rf_wdata_d = head_data;
            rf_src_d   = SRC_LU;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= SRC_NONE;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_src   = rf_src_q;

`ifdef WB_ARB_STARVE_EN
    localparam int               AGE_W   = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] age_q, age_d;
    logic             starve_q, starve_d;
    logic             nonempty_next;

    always_comb begin
        // Age of the current head: restarts whenever the head leaves or the
        // FIFO is empty, otherwise counts up and saturates.
        age_d = age_q;
        if (lu_pop || fifo_empty) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
        nonempty_next = lu_push ||
                        !(fifo_empty || (lu_pop && (fifo_count == CNT_W'(1))));
        // Registered from next-state values so starve_stall always reflects the
        // age and occupancy visible in the same cycle; it drops right after the
        // head pops.
        starve_d = (age_d >= AGE_MAX) && nonempty_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            age_q    <= age_d;
            starve_q <= starve_d;
        end
    end

    assign starve_stall = starve_q;
`else
    // MAX_WAIT only sizes the age counter; it is referenced here so the
    // parameter remains part of the interface when the counter is absent.
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT > 0);
    assign starve_stall    = 1'b0;
`endif

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Randomised and directed stimulus against a queue-based reference model.
//   Expected register-file writes go into a scoreboard queue; a monitor pops
//   and compares them whenever the DUT asserts rf_we.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    typedef struct {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic [1:0]        src;
    } wr_t;

    typedef struct {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wb_valid = 1'b0;
    logic [REG_AW-1:0] wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              lu_valid = 1'b0;
    logic [REG_AW-1:0] lu_rd = '0;
    logic [XLEN-1:0]   lu_data = '0;
    logic              lu_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic [1:0]        rf_src;
    logic              lu_pending;
    logic              starve_stall;

    wb_port_arbiter #(
        .XLEN     (XLEN),
        .REG_AW   (REG_AW),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .rf_src       (rf_src),
        .lu_pending   (lu_pending),
        .starve_stall (starve_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the DUT outputs should show right now.
    ent_t              mq[$];
    wr_t               sb[$];
    int                m_age    = 0;
    bit                m_we     = 1'b0;
    logic [REG_AW-1:0] m_rd     = '0;
    logic [XLEN-1:0]   m_data   = '0;
    bit                m_starve = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_age    = 0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        m_starve = 1'b0;
    endtask

    // Compare the level outputs against the model at the current negedge.
    task automatic check_state();
        check("lu_ready",     64'(lu_ready),     64'(mq.size() != DEPTH));
        check("lu_pending",   64'(lu_pending),   64'(mq.size() != 0));
        check("starve_stall", 64'(starve_stall), 64'(m_starve));
        check("rf_we",        64'(rf_we),        64'(m_we));
        if (!m_we) begin
            check("idle_rf_rd",    64'(rf_rd),    64'(m_rd));
            check("idle_rf_wdata", 64'(rf_wdata), 64'(m_data));
            check("idle_rf_src",   64'(rf_src),   64'(SRC_NONE));
        end
    endtask

    // One clock of stimulus: check the visible state, drive inputs, advance the model.
    task automatic step(input bit wv, input logic [REG_AW-1:0] wrd, input logic [XLEN-1:0] wd,
                        input bit lv, input logic [REG_AW-1:0] lrd, input logic [XLEN-1:0] ld);
        bit   rdy, pipe, push, pop, was_empty;
        ent_t e;
        @(negedge clk);
        check_state();
        wb_valid = wv;  wb_rd = wrd;  wb_data = wd;
        lu_valid = lv;  lu_rd = lrd;  lu_data = ld;

        rdy       = (mq.size() < DEPTH);
        was_empty = (mq.size() == 0);
        pipe      = wv && (wrd != 0);
        push      = lv && rdy && (lrd != 0);
        pop       = !pipe && !was_empty;
        if (pipe) begin
            sb.push_back('{rd: wrd, data: wd, src: SRC_PIPE});
            m_we = 1'b1;  m_rd = wrd;  m_data = wd;
        end else if (pop) begin
            e = mq.pop_front();
            sb.push_back('{rd: e.rd, data: e.data, src: SRC_LU});
            m_we = 1'b1;  m_rd = e.rd;  m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (push) mq.push_back('{rd: lrd, data: ld});
        if (pop || was_empty) m_age = 0;
        else if (m_age < MAX_WAIT) m_age++;
        m_starve = STARVE_ON && (m_age >= MAX_WAIT) && (mq.size() != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_state();
            check("reset_rf_rd",    64'(rf_rd),    64'(0));
            check("reset_rf_wdata", 64'(rf_wdata), 64'(0));
        end
        reset_n = 1'b1;
    endtask

    // Monitor: every DUT write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && rf_we) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                             rf_rd, rf_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wr_rd",   64'(rf_rd),    64'(e.rd));
                    check("wr_data", 64'(rf_wdata), 64'(e.data));
                    check("wr_src",  64'(rf_src),   64'(e.src));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for three cycles.
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_state();
        end
        reset_n = 1'b1;

        // Pipeline only.
        step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        idle(2);

        // Conflict: LU result waits behind three pipeline writes.
        step(1'b1, 5'd3, 32'h0301, 1'b1, 5'd7, 32'hAA);
        step(1'b1, 5'd3, 32'h0302, 1'b0, '0, '0);
        step(1'b1, 5'd3, 32'h0303, 1'b0, '0, '0);
        idle(2);

        // Fill the FIFO under constant pipeline pressure, then drain in order.
        step(1'b1, 5'd3, 32'h0401, 1'b1, 5'd9,  32'h11);
        step(1'b1, 5'd3, 32'h0402, 1'b1, 5'd10, 32'h22);
        step(1'b1, 5'd3, 32'h0403, 1'b1, 5'd11, 32'h33);
        step(1'b1, 5'd3, 32'h0404, 1'b0, '0, '0);
        idle(3);

        // Writes to x0 from either source are discarded.
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        idle(2);

        // Head starvation under continuous pipeline writes, then a gap.
        step(1'b0, '0, '0, 1'b1, 5'd12, 32'h55);
        for (int i = 0; i < 7; i++) step(1'b1, 5'd4, 32'(32'h0600 + i), 1'b0, '0, '0);
        idle(3);

        // Reset while entries are still queued discards them.
        step(1'b1, 5'd6, 32'h0701, 1'b1, 5'd13, 32'h66);
        step(1'b1, 5'd6, 32'h0702, 1'b1, 5'd14, 32'h77);
        apply_reset(2);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            bit                wv, lv;
            logic [REG_AW-1:0] wrd, lrd;
            wv  = ($urandom_range(0, 9) < 6);
            lv  = ($urandom_range(0, 9) < 5);
            wrd = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom_range(1, 31));
            lrd = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom_range(1, 31));
            step(wv, wrd, XLEN'($urandom), lv, lrd, XLEN'($urandom));
        end
        idle(DEPTH + 3);

        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        check("fifo_model_empty", 64'(lu_pending), 64'(mq.size() != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_port_arbiter
